// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low segment codes (a..g, MSB = a),
// the blank anode pattern and the digit type used by driver and capture sides.
package ssd_pkg;

  typedef logic [3:0] ssd_digit_t;

  localparam logic [3:0] SSD_BLANK_AN = 4'b1111;

  localparam logic [6:0] SSD_CODE_0 = 7'b0000001;
  localparam logic [6:0] SSD_CODE_1 = 7'b1001111;
  localparam logic [6:0] SSD_CODE_2 = 7'b0010010;
  localparam logic [6:0] SSD_CODE_3 = 7'b0000110;
  localparam logic [6:0] SSD_CODE_4 = 7'b1001100;
  localparam logic [6:0] SSD_CODE_5 = 7'b0100100;
  localparam logic [6:0] SSD_CODE_6 = 7'b0100000;
  localparam logic [6:0] SSD_CODE_7 = 7'b0001111;
  localparam logic [6:0] SSD_CODE_8 = 7'b0000000;
  localparam logic [6:0] SSD_CODE_9 = 7'b0000100;
  localparam logic [6:0] SSD_CODE_A = 7'b0001000;
  localparam logic [6:0] SSD_CODE_B = 7'b1100000;
  localparam logic [6:0] SSD_CODE_C = 7'b0110001;
  localparam logic [6:0] SSD_CODE_D = 7'b1000010;
  localparam logic [6:0] SSD_CODE_E = 7'b0110000;
  localparam logic [6:0] SSD_CODE_F = 7'b0111000;

endpackage

// File: rtl/ssd_segment_decode.sv
// Combinational inverse of the hex-to-segment table: active-low a..g pattern
// to hex value, with a flag for patterns that are not one of the 16 codes.
module ssd_segment_decode
  import ssd_pkg::*;
(
  input  logic [6:0]  seg,
  output logic        legal,
  output ssd_digit_t  value
);

  always_comb begin
    legal = 1'b1;
    value = 4'h0;
    case (seg)
      SSD_CODE_0: value = 4'h0;
      SSD_CODE_1: value = 4'h1;
      SSD_CODE_2: value = 4'h2;
      SSD_CODE_3: value = 4'h3;
      SSD_CODE_4: value = 4'h4;
      SSD_CODE_5: value = 4'h5;
      SSD_CODE_6: value = 4'h6;
      SSD_CODE_7: value = 4'h7;
      SSD_CODE_8: value = 4'h8;
      SSD_CODE_9: value = 4'h9;
      SSD_CODE_A: value = 4'hA;
      SSD_CODE_B: value = 4'hB;
      SSD_CODE_C: value = 4'hC;
      SSD_CODE_D: value = 4'hD;
      SSD_CODE_E: value = 4'hE;
      SSD_CODE_F: value = 4'hF;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_capture_decoder.sv
// Loopback monitor for a 4-digit multiplexed seven-segment driver: rebuilds the
// displayed hex digits, flags bad segment/anode patterns and marks full scans.
module ssd_capture_decoder
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = 1,
  parameter int RUN_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ssd_cathode,
  input  logic [3:0]  ssd_anode,
  output ssd_digit_t  ones,
  output ssd_digit_t  tens,
  output ssd_digit_t  hundreds,
  output ssd_digit_t  thousands,
  output logic [3:0]  digit_valid,
  output logic [3:0]  dp_on,
  output logic        frame_strobe,
  output logic        seg_error,
  output logic        anode_error
);

  localparam logic [RUN_W-1:0] STABLE = RUN_W'(STABLE_CYCLES);

  logic [3:0]       s_an, p_an;
  logic [7:0]       s_cat, p_cat;
  logic [RUN_W-1:0] run_q, run_next;
  logic             changed, capture;
  logic             idx_ok, an_bad, legal;
  logic [1:0]       idx;
  logic [3:0]       bit_mask;
  logic             frame_done;
  ssd_digit_t       value;
  ssd_digit_t       digit_q [4];
  logic [3:0]       valid_q, dp_q, seen_q;

  ssd_segment_decode u_decode (
    .seg   (s_cat[7:1]),
    .legal (legal),
    .value (value)
  );

  // A capture fires only on the cycle the run first reaches STABLE; a
  // saturated run that keeps holding must not re-capture.
  always_comb begin
    changed  = {s_an, s_cat} != {p_an, p_cat};
    run_next = changed ? RUN_W'(1)
             : (run_q >= STABLE) ? STABLE : run_q + RUN_W'(1);
    capture  = (run_next == STABLE) && (changed || (run_q != STABLE));
  end

  always_comb begin
    idx_ok = 1'b0;
    an_bad = 1'b0;
    idx    = 2'd0;
    case (s_an)
      4'b1110:      begin idx_ok = 1'b1; idx = 2'd0; end
      4'b1101:      begin idx_ok = 1'b1; idx = 2'd1; end
      4'b1011:      begin idx_ok = 1'b1; idx = 2'd2; end
      4'b0111:      begin idx_ok = 1'b1; idx = 2'd3; end
      SSD_BLANK_AN: ;
      default:      an_bad = 1'b1;
    endcase
    bit_mask   = 4'b0001 << idx;
    frame_done = (seen_q | bit_mask) == 4'b1111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_an         <= SSD_BLANK_AN;
      s_cat        <= 8'hFF;
      p_an         <= SSD_BLANK_AN;
      p_cat        <= 8'hFF;
      run_q        <= '0;
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'h0;
      valid_q      <= 4'b0000;
      dp_q         <= 4'b0000;
      seen_q       <= 4'b0000;
      frame_strobe <= 1'b0;
      seg_error    <= 1'b0;
      anode_error  <= 1'b0;
    end else begin
      s_an         <= ssd_anode;
      s_cat        <= ssd_cathode;
      p_an         <= s_an;
      p_cat        <= s_cat;
      run_q        <= run_next;
      frame_strobe <= 1'b0;
      seg_error    <= 1'b0;
      anode_error  <= 1'b0;
      if (capture) begin
        if (an_bad) begin
          anode_error <= 1'b1;
        end else if (idx_ok) begin
          if (legal) begin
            digit_q[idx] <= value;
            valid_q[idx] <= 1'b1;
            dp_q[idx]    <= ~s_cat[0];
            if (frame_done) begin
              frame_strobe <= 1'b1;
              seen_q       <= 4'b0000;
            end else begin
              seen_q <= seen_q | bit_mask;
            end
          end else begin
            seg_error    <= 1'b1;
            valid_q[idx] <= 1'b0;
          end
        end
      end
    end
  end

  assign ones        = digit_q[0];
  assign tens        = digit_q[1];
  assign hundreds    = digit_q[2];
  assign thousands   = digit_q[3];
  assign digit_valid = valid_q;
  assign dp_on       = dp_q;

endmodule

// File: tb/tb_ssd_capture_decoder.sv
// Directed bench for ssd_capture_decoder at STABLE_CYCLES = 1 and 3, checked
// cycle by cycle against a spec-level model through an expected queue.
module tb_ssd_capture_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] an1, an3;
  logic [7:0] cat1, cat3;
  logic [3:0] o1, t1, h1, k1, v1, d1, o3, t3, h3, k3, v3, d3;
  logic       f1, se1, ae1, f3, se3, ae3;

  ssd_capture_decoder #(.STABLE_CYCLES(1), .RUN_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .ssd_cathode(cat1), .ssd_anode(an1),
    .ones(o1), .tens(t1), .hundreds(h1), .thousands(k1),
    .digit_valid(v1), .dp_on(d1), .frame_strobe(f1),
    .seg_error(se1), .anode_error(ae1)
  );

  ssd_capture_decoder #(.STABLE_CYCLES(3), .RUN_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .ssd_cathode(cat3), .ssd_anode(an3),
    .ones(o3), .tens(t3), .hundreds(h3), .thousands(k3),
    .digit_valid(v3), .dp_on(d3), .frame_strobe(f3),
    .seg_error(se3), .anode_error(ae3)
  );

  // Vector layout: {ones,tens,hundreds,thousands,digit_valid,dp_on,frame,seg_err,an_err}
  logic [26:0] exp_q[$];
  int          due_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cur_sel = 1;

  logic [6:0] codes [16];
  logic [3:0] m_dig [4];
  logic [3:0] m_valid, m_dp, m_seen, m_last_an;
  logic [7:0] m_last_cat;
  int         m_run, m_stable;

  function automatic logic [26:0] dut_vec(input int sel);
    if (sel == 1) return {o1, t1, h1, k1, v1, d1, f1, se1, ae1};
    return {o3, t3, h3, k3, v3, d3, f3, se3, ae3};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_valid    = 4'b0000;
    m_dp       = 4'b0000;
    m_seen     = 4'b0000;
    m_last_an  = 4'hF;
    m_last_cat = 8'hFF;
    m_run      = 0;
  endtask

  task automatic check(input string tag, input logic [26:0] got, input logic [26:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic advance();
    @(negedge clk);
    cyc++;
    while (due_q.size() > 0 && due_q[0] == cyc) begin
      check(tag_q.pop_front(), dut_vec(cur_sel), exp_q.pop_front());
      void'(due_q.pop_front());
    end
  endtask

  task automatic step(input string tag, input logic [3:0] an, input logic [7:0] cat,
                      input bit push = 1'b1);
    logic       fr, se, ae, legal, chg;
    logic [3:0] val, bitm;
    int         idx, prev_run;
    fr = 1'b0; se = 1'b0; ae = 1'b0; legal = 1'b0; val = 4'h0; idx = -1;
    if (cur_sel == 1) begin
      an1 = an; cat1 = cat; an3 = 4'hF; cat3 = 8'hFF;
    end else begin
      an3 = an; cat3 = cat; an1 = 4'hF; cat1 = 8'hFF;
    end
    chg      = {an, cat} != {m_last_an, m_last_cat};
    prev_run = m_run;
    if (chg) m_run = 1;
    else if (m_run < m_stable) m_run++;
    m_last_an  = an;
    m_last_cat = cat;
    if (m_run == m_stable && (chg || prev_run != m_stable)) begin
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        4'b1111: idx = -1;
        default: ae = 1'b1;
      endcase
      if (idx >= 0) begin
        for (int v = 0; v < 16; v++)
          if (codes[v] == cat[7:1]) begin legal = 1'b1; val = v[3:0]; end
        if (legal) begin
          bitm          = 4'b0001 << idx;
          m_dig[idx]    = val;
          m_valid[idx]  = 1'b1;
          m_dp[idx]     = ~cat[0];
          if ((m_seen | bitm) == 4'b1111) begin fr = 1'b1; m_seen = 4'b0000; end
          else m_seen = m_seen | bitm;
        end else begin
          se           = 1'b1;
          m_valid[idx] = 1'b0;
        end
      end
    end
    if (push) begin
      exp_q.push_back({m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_valid, m_dp, fr, se, ae});
      due_q.push_back(cyc + 2);
      tag_q.push_back(tag);
    end
    advance();
  endtask

  task automatic flush();
    repeat (2) step("flush", 4'hF, 8'hFF);
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) step("idle", 4'hF, 8'hFF, 1'b0);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL flush_timeout got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rv;
    codes[0]  = 7'b0000001; codes[1]  = 7'b1001111; codes[2]  = 7'b0010010;
    codes[3]  = 7'b0000110; codes[4]  = 7'b1001100; codes[5]  = 7'b0100100;
    codes[6]  = 7'b0100000; codes[7]  = 7'b0001111; codes[8]  = 7'b0000000;
    codes[9]  = 7'b0000100; codes[10] = 7'b0001000; codes[11] = 7'b1100000;
    codes[12] = 7'b0110001; codes[13] = 7'b1000010; codes[14] = 7'b0110000;
    codes[15] = 7'b0111000;

    // clock/reset
    rst_n = 1'b0;
    an1 = 4'hF; cat1 = 8'hFF; an3 = 4'hF; cat3 = 8'hFF;
    model_reset();
    m_stable = 1;
    cur_sel  = 1;
    repeat (3) @(negedge clk);
    check("reset_dut1", dut_vec(1), 27'h0);
    check("reset_dut3", dut_vec(3), 27'h0);
    rst_n = 1'b1;
    step("post_reset", 4'hF, 8'hFF);

    // driver-style scan 3,7,A,F every cycle
    for (int f = 0; f < 3; f++) begin
      step("scan_ones", 4'b1110, {codes[3], 1'b1});
      step("scan_tens", 4'b1101, {codes[7], 1'b1});
      step("scan_hund", 4'b1011, {codes[10], 1'b1});
      step("scan_thou", 4'b0111, {codes[15], 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      rv = 4'($urandom_range(0, 15));
      step("rand_scan", ~(4'b0001 << i), {codes[rv], 1'b1});
    end

    step("seg_err", 4'b1101, 8'hFF);
    step("seg_err_hold", 4'b1101, 8'hFF);
    step("an_err", 4'b1100, {codes[5], 1'b1});
    step("an_err_hold", 4'b1100, {codes[5], 1'b1});
    repeat (10) step("blank", 4'hF, 8'hFF);
    step("dp_ones", 4'b1110, {codes[9], 1'b0});
    step("tens_pre_rst", 4'b1101, {codes[1], 1'b1});
    flush();

    // asynchronous reset with a partial frame pending
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_dut1", dut_vec(1), 27'h0);
    check("rst_async_dut3", dut_vec(3), 27'h0);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    model_reset();
    step("re_hund", 4'b1011, {codes[8], 1'b1});
    step("re_thou", 4'b0111, {codes[0], 1'b1});
    step("re_ones", 4'b1110, {codes[1], 1'b1});
    step("re_tens", 4'b1101, {codes[2], 1'b1});
    flush();

    // STABLE_CYCLES = 3 instance
    cur_sel  = 3;
    m_stable = 3;
    model_reset();
    repeat (2) step("s3_short", 4'b1110, {codes[2], 1'b1});
    repeat (3) step("s3_gap", 4'hF, 8'hFF);
    repeat (5) step("s3_hold5", 4'b1110, {codes[2], 1'b1});
    repeat (3) step("s3_tens", 4'b1101, {codes[12], 1'b0});
    repeat (4) step("s3_an_err", 4'b0011, {codes[4], 1'b1});
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
